// File: rtl/matmul_seq_pkg.sv
// Shared opcode constants and FSM state encoding for the matmul APB sequencer.
// No logic; latency and backpressure are defined by the modules that import it.
// Opcodes match the two-bit cmd_op_i field pushed by the host.
package matmul_seq_pkg;

    localparam logic [1:0] OP_WRITE     = 2'b00;
    localparam logic [1:0] OP_READ      = 2'b01;
    localparam logic [1:0] OP_WAIT_IDLE = 2'b10;
    localparam logic [1:0] OP_RSVD      = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_POLL   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/matmul_seq_fifo.sv
// Generic synchronous FIFO with wrap-around pointers and full/empty flags.
// Latency: a pushed word is visible at rdata_o the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module matmul_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/matmul_apb_sequencer.sv
// Command FIFO driven APB master/busy poller for the matmul slave; optional MATMUL_SEQ_TIMEOUT_EN.
// Latency: zero-wait command gives SETUP, ACCESS, then response on three successive edges.
// Backpressure: cmd_ready_o low while FIFO full; one response held until rsp_ready_i.
module matmul_apb_sequencer
    import matmul_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int BUS_WIDTH      = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int MAX_DIM       = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_data_i,
    input  logic [MAX_DIM-1:0]    cmd_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [MAX_DIM-1:0]    pstrb_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i,
    input  logic                  mm_busy_i,
    output logic                  seq_busy_o
);

    localparam int CMD_W = 2 + ADDR_WIDTH + BUS_WIDTH + MAX_DIM;

    logic [CMD_W-1:0]      fifo_rdata;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [1:0]            head_op;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [BUS_WIDTH-1:0]  head_data;
    logic [MAX_DIM-1:0]    head_strb;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
    logic [MAX_DIM-1:0]    strb_q, strb_d;
    logic [BUS_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  bus_act;

    matmul_seq_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_valid_i),
        .wdata_i ({cmd_op_i, cmd_addr_i, cmd_data_i, cmd_strb_i}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_op, head_addr, head_data, head_strb} = fifo_rdata;

`ifdef MATMUL_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        fifo_pop   = 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = head_op;
                    // Bus-facing fields only change for real transfers so the APB outputs hold otherwise.
                    if (head_op == OP_WRITE || head_op == OP_READ) begin
                        addr_d  = head_addr;
                        wdata_d = head_data;
                        strb_d  = head_strb;
                        state_d = ST_SETUP;
                    end else if (head_op == OP_WAIT_IDLE) begin
                        state_d = ST_POLL;
`ifdef MATMUL_SEQ_TIMEOUT_EN
                        tmo_cnt_d = '0;
`endif
                    end else begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef MATMUL_SEQ_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    rsp_data_d = (op_q == OP_READ) ? prdata_i : '0;
                    rsp_err_d  = pslverr_i;
                    state_d    = ST_RESP;
                end
`ifdef MATMUL_SEQ_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
`endif
            end
            ST_POLL: begin
                if (!mm_busy_i) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end
`ifdef MATMUL_SEQ_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_WRITE;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
`ifdef MATMUL_SEQ_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    // APB controls decode straight from the registered state: no path from pready_i.
    assign bus_act     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign psel_o      = bus_act;
    assign penable_o   = (state_q == ST_ACCESS);
    assign pwrite_o    = bus_act && (op_q == OP_WRITE);
    assign paddr_o     = addr_q;
    assign pwdata_o    = wdata_q;
    assign pstrb_o     = strb_q;
    assign cmd_ready_o = !fifo_full;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign seq_busy_o  = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_matmul_apb_sequencer.sv
// Directed bench for matmul_apb_sequencer: APB write/read, wait states, FIFO fill, polling, errors, reset.
// Checks run one time unit after each rising edge; a small echo slave supplies read data.
module tb_matmul_apb_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i = 2'b00;
    logic [31:0] cmd_addr_i = '0;
    logic [15:0] cmd_data_i = '0;
    logic [1:0]  cmd_strb_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [15:0] rsp_data_o;
    logic        rsp_err_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] paddr_o;
    logic [15:0] pwdata_o;
    logic [1:0]  pstrb_o;
    logic        pready_i = 1'b1;
    logic        pslverr_i = 1'b0;
    logic [15:0] prdata_i;
    logic        mm_busy_i = 1'b0;
    logic        seq_busy_o;

    logic        echo = 1'b0;
    logic [15:0] prdata_r = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    assign prdata_i = echo ? (paddr_o[15:0] + 16'h1000) : prdata_r;

    always #5 clk_i = ~clk_i;

    matmul_apb_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_strb_i(cmd_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready_i),
        .pslverr_i(pslverr_i), .prdata_i(prdata_i), .mm_busy_i(mm_busy_i), .seq_busy_o(seq_busy_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic [31:0] addr,
                           input logic [15:0] data, input logic [1:0] strb);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
        cmd_strb_i  = strb;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid_o && n < 40) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, rsp_valid_o}, 32'd1);
    endtask

    initial begin
        // Reset state, observed without any clock edge
        #2;
        chk("rst_psel", {31'd0, psel_o}, 32'd0);
        chk("rst_penable", {31'd0, penable_o}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_seq_busy", {31'd0, seq_busy_o}, 32'd0);
        chk("rst_paddr", paddr_o, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // WRITE 0x0 <= 0x0003, zero-wait slave
        set_cmd(2'b00, 32'h0, 16'h0003, 2'b11);
        tick();
        cmd_valid_i = 1'b0;
        chk("wr_e0_psel", {31'd0, psel_o}, 32'd0);
        chk("wr_e0_busy", {31'd0, seq_busy_o}, 32'd1);
        tick();
        chk("wr_setup_psel", {31'd0, psel_o}, 32'd1);
        chk("wr_setup_pen", {31'd0, penable_o}, 32'd0);
        chk("wr_setup_pwrite", {31'd0, pwrite_o}, 32'd1);
        chk("wr_setup_pwdata", {16'd0, pwdata_o}, 32'h3);
        chk("wr_setup_pstrb", {30'd0, pstrb_o}, 32'h3);
        tick();
        chk("wr_access_pen", {31'd0, penable_o}, 32'd1);
        chk("wr_access_psel", {31'd0, psel_o}, 32'd1);
        tick();
        chk("wr_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("wr_rsp_data", {16'd0, rsp_data_o}, 32'd0);
        chk("wr_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        chk("wr_rsp_psel", {31'd0, psel_o}, 32'd0);
        chk("wr_rsp_pwrite", {31'd0, pwrite_o}, 32'd0);
        chk("wr_rsp_pwdata_hold", {16'd0, pwdata_o}, 32'h3);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("wr_done_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("wr_done_busy", {31'd0, seq_busy_o}, 32'd0);

        // READ 0x10 with two wait states, slave returns 0xA55A
        pready_i = 1'b0;
        set_cmd(2'b01, 32'h10, 16'h0, 2'b00);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        chk("rd_setup_paddr", paddr_o, 32'h10);
        chk("rd_setup_pwrite", {31'd0, pwrite_o}, 32'd0);
        tick();
        chk("rd_acc1_pen", {31'd0, penable_o}, 32'd1);
        tick();
        chk("rd_acc2_pen", {31'd0, penable_o}, 32'd1);
        tick();
        chk("rd_acc3_pen", {31'd0, penable_o}, 32'd1);
        chk("rd_acc3_valid", {31'd0, rsp_valid_o}, 32'd0);
        pready_i = 1'b1;
        prdata_r = 16'hA55A;
        tick();
        prdata_r = 16'h0000;
        chk("rd_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("rd_rsp_data", {16'd0, rsp_data_o}, 32'hA55A);
        chk("rd_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        chk("rd_rsp_penable", {31'd0, penable_o}, 32'd0);

        // Hold the READ response and push five READs: only four fit
        for (int k = 0; k < 5; k++) begin
            set_cmd(2'b01, 32'h20 + k, 16'h0, 2'b00);
            chk($sformatf("fill_ready_%0d", k), {31'd0, cmd_ready_o}, (k < 4) ? 32'd1 : 32'd0);
            tick();
        end
        cmd_valid_i = 1'b0;
        chk("fill_ready_after", {31'd0, cmd_ready_o}, 32'd0);
        chk("fill_rsp_stable", {16'd0, rsp_data_o}, 32'hA55A);
        echo = 1'b1;
        rsp_ready_i = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            wait_rsp($sformatf("drain_wait_%0d", k));
            chk($sformatf("drain_data_%0d", k), {16'd0, rsp_data_o}, 32'h1020 + k);
            tick();
        end
        repeat (6) tick();
        chk("drain_no_fifth", {31'd0, seq_busy_o}, 32'd0);
        chk("drain_last_paddr", paddr_o, 32'h23);
        echo = 1'b0;
        rsp_ready_i = 1'b0;

        // WAIT_IDLE with matmul busy for about 20 cycles
        mm_busy_i = 1'b1;
        set_cmd(2'b10, 32'h0, 16'h0, 2'b00);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        chk("poll_psel", {31'd0, psel_o}, 32'd0);
        chk("poll_busy", {31'd0, seq_busy_o}, 32'd1);
        repeat (18) tick();
        chk("poll_still_waiting", {31'd0, rsp_valid_o}, 32'd0);
        mm_busy_i = 1'b0;
        tick();
        chk("poll_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("poll_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        chk("poll_rsp_data", {16'd0, rsp_data_o}, 32'd0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // Reserved opcode: error response, no APB activity, bus outputs hold
        set_cmd(2'b11, 32'h99, 16'hFFFF, 2'b11);
        tick();
        cmd_valid_i = 1'b0;
        chk("rsvd_e0_psel", {31'd0, psel_o}, 32'd0);
        tick();
        chk("rsvd_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("rsvd_rsp_err", {31'd0, rsp_err_o}, 32'd1);
        chk("rsvd_rsp_data", {16'd0, rsp_data_o}, 32'd0);
        chk("rsvd_psel", {31'd0, psel_o}, 32'd0);
        chk("rsvd_paddr_hold", paddr_o, 32'h23);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // READ answered with pslverr
        pslverr_i = 1'b1;
        prdata_r  = 16'h1234;
        set_cmd(2'b01, 32'h30, 16'h0, 2'b00);
        tick();
        cmd_valid_i = 1'b0;
        wait_rsp("slverr_wait");
        chk("slverr_err", {31'd0, rsp_err_o}, 32'd1);
        chk("slverr_data", {16'd0, rsp_data_o}, 32'h1234);
        pslverr_i = 1'b0;
        prdata_r  = 16'h0;
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // Reset asserted during ACCESS with a second command queued
        pready_i = 1'b0;
        set_cmd(2'b00, 32'h40, 16'h5555, 2'b01);
        tick();
        set_cmd(2'b00, 32'h44, 16'h6666, 2'b10);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        chk("mid_access_psel", {31'd0, psel_o}, 32'd1);
        chk("mid_access_pen", {31'd0, penable_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_psel", {31'd0, psel_o}, 32'd0);
        chk("mid_rst_pen", {31'd0, penable_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("mid_rst_busy", {31'd0, seq_busy_o}, 32'd0);
        @(negedge clk_i);
        rst_ni   = 1'b1;
        pready_i = 1'b1;
        repeat (4) tick();
        chk("post_rst_busy", {31'd0, seq_busy_o}, 32'd0);
        chk("post_rst_psel", {31'd0, psel_o}, 32'd0);
        chk("post_rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
